// File: rtl/umem_arbiter_if.sv
// Unified-memory port bundle: request/handshake towards memory and the returned read data.
// The arbiter drives the master side, the memory (or its model) the slave side.
interface umem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              u_re;
  logic              u_we;
  logic [ADDR_W-1:0] u_addr;
  logic [DATA_W-1:0] u_wdata;
  logic              u_rdy;
  logic [DATA_W-1:0] u_rdata;

  modport master (
    output u_re,
    output u_we,
    output u_addr,
    output u_wdata,
    input  u_rdy,
    input  u_rdata
  );

  modport slave (
    input  u_re,
    input  u_we,
    input  u_addr,
    input  u_wdata,
    output u_rdy,
    output u_rdata
  );
endinterface

// File: rtl/umem_arbiter.sv
// Shares the unified-memory port between I-cache fills and D-cache evicts/fills, with a watchdog.
// Optional macro UMEM_ARB_STARVE_GUARD_EN caps consecutive D grants while I is waiting.
module umem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int TIMEOUT      = 255,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  umem_arbiter_if.master    mem,
  output logic [DATA_W-1:0] rdata,
  output logic              i_done,
  output logic              d_done,
  output logic              busy,
  output logic              err
);

  localparam int             CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TIMEOUT_CMP = (CNT_W + 1)'(TIMEOUT);

  if (TIMEOUT < 0 || MAX_D_STREAK < 0) begin : g_bad_param
    $error("umem_arbiter: TIMEOUT and MAX_D_STREAK must be non-negative");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;

  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              i_done_d, d_done_d, busy_d, err_d;

  logic              grant_i, grant_d;
  logic              finish, timed_out;
  logic              force_i;

`ifdef UMEM_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = (MAX_D_STREAK < 7) ? 3 : $clog2(MAX_D_STREAK + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;

  // I has waited through MAX_D_STREAK D grants: it takes the next slot.
  assign force_i = i_req && (streak_q == STREAK_W'(MAX_D_STREAK));
`else
  assign force_i = 1'b0;
`endif

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  assign mem.u_re    = re_q;
  assign mem.u_we    = we_q;
  assign mem.u_addr  = addr_q;
  assign mem.u_wdata = wdata_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin : next_state
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req && !force_i) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_i || grant_d) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // A response on the last allowed cycle still wins over the watchdog.
        timed_out = (TIMEOUT != 0) && !mem.u_rdy && (cnt_inc == TIMEOUT_CMP);
        finish    = mem.u_rdy || timed_out;
        if (finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : output_next
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    re_d     = re_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata;
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    err_d    = 1'b0;
`ifdef UMEM_ARB_STARVE_GUARD_EN
    streak_d = streak_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          cnt_d   = '0;
          re_d    = !d_wr;
          we_d    = d_wr;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (grant_i) begin
          owner_d = OWN_I;
          cnt_d   = '0;
          re_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
        end
`ifdef UMEM_ARB_STARVE_GUARD_EN
        if (!i_req || grant_i) begin
          streak_d = '0;
        end else if (grant_d) begin
          streak_d = streak_q + STREAK_W'(1);
        end
`endif
      end
      S_BUSY: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        if (finish) begin
          re_d     = 1'b0;
          we_d     = 1'b0;
          i_done_d = (owner_q == OWN_I);
          d_done_d = (owner_q == OWN_D);
          err_d    = timed_out;
          if (mem.u_rdy && re_q) begin
            rdata_d = mem.u_rdata;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the values
  // of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      cnt_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
`ifdef UMEM_ARB_STARVE_GUARD_EN
      streak_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      i_done  <= i_done_d;
      d_done  <= d_done_d;
      busy    <= busy_d;
      err     <= err_d;
`ifdef UMEM_ARB_STARVE_GUARD_EN
      streak_q <= streak_d;
`endif
    end
  end

endmodule
